gcm_tag_verify: RTL
===================

# gcm_tag_verify

Receive-side GCM authentication block for the decrypt path. It accumulates GHASH over a stream of 128-bit AAD/ciphertext blocks using a digit-serial GF(2^128) multiplier. It then folds in the length block, XORs in E(K, J0), and compares the result against the received tag. It is the verifying counterpart of the encrypt pipeline's final tag-generation stage and sits beside the CTR decrypt pipeline, consuming the same blocks that pipeline consumes.

## Interface
- DIGIT_BITS, 8, multiplier bits processed per cycle; must divide 128; N = 128/DIGIT_BITS cycles per multiply
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse; loads the four operands below; honoured only in IDLE
- i_h  in  [0:127]  hash subkey H = E(K, 0^128)
- i_encrypted_j0  in  [0:127]  E(K, J0)
- i_instance_size  in  [0:127]  GCM length block, len(A)||len(C), in bits
- i_tag  in  [0:127]  received tag to check
- i_valid  in  1  i_cipher_text/i_last valid
- i_cipher_text  in  [0:127]  AAD or ciphertext block, already zero-padded
- i_last  in  1  marks the final data block
- o_ready  out  1  block accepted on i_valid & o_ready
- o_busy  out  1  high in every state except IDLE
- o_tag_ready  out  1  one-cycle pulse: result valid
- o_tag_ok  out  1  computed tag equals i_tag; held until next i_start/rst
- o_tag  out  [0:127]  computed tag; held until next i_start/rst

## Operation
- States: IDLE, WAIT_BLK, MULT, FINAL, DONE.
- IDLE: o_ready=0. On i_start, register operands, clear Y to 0, clear o_tag/o_tag_ok, and go to WAIT_BLK. i_start in any other state is ignored.
- WAIT_BLK: o_ready=1. On accept, X = Y ^ i_cipher_text, latch i_last, go to MULT.
- MULT: Y ← X·H over N cycles. On the Nth cycle, go to FINAL if the latched last flag is set, else WAIT_BLK.
- FINAL: X = Y ^ r_instance_size, then Y ← X·H over N cycles, then go to DONE.
- DONE: o_tag = Y ^ r_encrypted_j0 is registered on entry. o_tag_ready=1 for this single cycle; o_tag_ok = (o_tag == r_tag). Next state is IDLE.
- Multiply (GCM bit order, index 0 = MSB of x^0 coefficient): Z=0, V=H.
  - For bit i = 0..127 of X: if X[i], then Z ^= V.
  - V = V[127] ? (V>>1) ^ R : V>>1, where R = E1 followed by 120 zero bits.
  - ">>1" moves bits toward higher index. DIGIT_BITS steps are unrolled per cycle.
- Comparison covers the full 128 bits; tag truncation is out of scope.
- A message holds at least one block; AAD blocks precede ciphertext blocks on the same port, with no distinction.

## Timing
- Reset values: o_ready=0, o_busy=0, o_tag_ready=0, o_tag_ok=0, o_tag=0, state=IDLE.
- rst in any state, including mid-MULT or FINAL, returns to IDLE next cycle. The accumulator is discarded and no o_tag_ready is produced.
- Block throughput is one per N+1 cycles. o_ready is low throughout MULT, FINAL, and DONE.
- i_start at edge t puts o_ready high in cycle t+1.
- Last block accepted at edge t produces o_tag_ready in cycle t+2N+1 (N MULT + N FINAL + DONE). With DIGIT_BITS=8 this is t+33.
- i_valid low in WAIT_BLK stalls indefinitely; there is no timeout.
- o_tag_ok is registered, aligned with o_tag_ready, and holds afterwards.
- o_busy is combinational from state.

## Structure
- Shared package aes_gcm_pkg holds:
  - BLOCK_W=128
  - GHASH_R constant (E1 followed by 120 zeros)
  - fn_product (used as the bench reference model)
  - state enum typedef for this block
- One sub-module: gf128_mult_serial (start/done, parameter DIGIT_BITS). It holds Z, V, X, and a log2(N)-bit digit counter. The FSM drives it for both MULT and FINAL.

## Test plan
- NIST GCM test case 2:
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, E(J0)=58e2fccefa7e3061367f1d57a4e7455a, len=0…0080, one block 0388dace60b6a392f328c2b971b2fe78 with i_last=1, i_tag=ab6e47d42cec13bdf53a67b21257bddf.
  - Required response: o_tag=ab6e47d4…bddf, o_tag_ok=1, o_tag_ready exactly 33 cycles after accept.
- Same as the first scenario with i_tag bit 127 flipped → o_tag unchanged, o_tag_ok=0.
- Multi-block, randomized i_valid gaps (4 blocks, random data) → o_tag matches the fn_product model, and no block is accepted while o_ready=0.
- i_start pulsed during MULT → ignored; result identical to an undisturbed run.
- rst asserted mid-FINAL → next cycle IDLE, all outputs 0, no o_tag_ready. A following clean run of the first scenario passes.
- DIGIT_BITS=1 and DIGIT_BITS=16 builds on the first scenario → same tag. Latency is 257 and 17 cycles respectively.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared GCM definitions: block width, GHASH reduction constant,
// FSM state type and a bit-serial reference GF(2^128) product.
package aes_gcm_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [0:BLOCK_W-1] blk_t;

  // E1 followed by 120 zero bits
  localparam blk_t GHASH_R = {8'he1, 120'd0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_MULT,
    S_FINAL,
    S_DONE
  } gtv_state_e;

  // One V update: shift toward higher index, reduce on carry-out
  function automatic blk_t fn_vshift(blk_t v);
    blk_t s;
    s = v >> 1;
    if (v[BLOCK_W-1]) s = s ^ GHASH_R;
    return s;
  endfunction

  function automatic blk_t fn_product(blk_t x, blk_t h);
    blk_t z;
    blk_t v;
    z = '0;
    v = h;
    for (int i = 0; i < BLOCK_W; i++) begin
      if (x[i]) z = z ^ v;
      v = fn_vshift(v);
    end
    return z;
  endfunction

endpackage

// File: rtl/gf128_mult_serial.sv
// Digit-serial GF(2^128) multiplier, DIGIT_BITS bits of X per cycle.
// Ports: clk_i, rst_i, start_i, x_i, h_i in; done_o, prod_o out.
module gf128_mult_serial
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [0:BLOCK_W-1] x_i,
  input  logic [0:BLOCK_W-1] h_i,
  output logic               done_o,
  output logic [0:BLOCK_W-1] prod_o
);

  localparam int N  = BLOCK_W / DIGIT_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  blk_t z_q, z_d;
  blk_t v_q, v_d;
  blk_t x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;

  blk_t z_step, v_step;

  // Consume the leading DIGIT_BITS of X; X is shifted toward index 0
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      if (x_q[i]) z_step = z_step ^ v_step;
      v_step = fn_vshift(v_step);
    end
  end

  // Product is presented combinationally on the final digit cycle
  assign done_o = run_q && (cnt_q == LAST);
  assign prod_o = z_step;

  always_comb begin
    z_d   = z_q;
    v_d   = v_q;
    x_d   = x_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      z_d   = '0;
      v_d   = h_i;
      x_d   = x_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      z_d   = z_step;
      v_d   = v_step;
      x_d   = x_q << DIGIT_BITS;
      cnt_d = cnt_q + CW'(1);
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      z_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      v_q   <= v_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/gcm_tag_verify.sv
// GCM receive-side tag check: GHASH over blocks, length fold, E(K,J0) XOR.
// Ports: start/operands, valid/ready block stream, tag_ready/tag_ok/tag.
module gcm_tag_verify
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [0:BLOCK_W-1] i_h,
  input  logic [0:BLOCK_W-1] i_encrypted_j0,
  input  logic [0:BLOCK_W-1] i_instance_size,
  input  logic [0:BLOCK_W-1] i_tag,
  input  logic               i_valid,
  input  logic [0:BLOCK_W-1] i_cipher_text,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_tag_ready,
  output logic               o_tag_ok,
  output logic [0:BLOCK_W-1] o_tag
);

  gtv_state_e state_q, state_d;
  blk_t h_q, h_d;
  blk_t j0_q, j0_d;
  blk_t len_q, len_d;
  blk_t tag_q, tag_d;
  blk_t y_q, y_d;
  blk_t otag_q, otag_d;
  logic last_q, last_d;
  logic ok_q, ok_d;

  logic mul_start;
  blk_t mul_x;
  logic mul_done;
  blk_t mul_prod;

  gf128_mult_serial #(
    .DIGIT_BITS(DIGIT_BITS)
  ) u_mult (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(mul_start),
    .x_i    (mul_x),
    .h_i    (h_q),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  assign o_ready     = (state_q == S_WAIT_BLK);
  assign o_busy      = (state_q != S_IDLE);
  assign o_tag_ready = (state_q == S_DONE);
  assign o_tag_ok    = ok_q;
  assign o_tag       = otag_q;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    j0_d      = j0_q;
    len_d     = len_q;
    tag_d     = tag_q;
    y_d       = y_q;
    otag_d    = otag_q;
    last_d    = last_q;
    ok_d      = ok_q;
    mul_start = 1'b0;
    mul_x     = y_q ^ i_cipher_text;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          h_d     = i_h;
          j0_d    = i_encrypted_j0;
          len_d   = i_instance_size;
          tag_d   = i_tag;
          y_d     = '0;
          otag_d  = '0;
          ok_d    = 1'b0;
          state_d = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        if (i_valid) begin
          mul_start = 1'b1;
          last_d    = i_last;
          state_d   = S_MULT;
        end
      end
      S_MULT: begin
        // Last block chains straight into the length-block multiply
        if (mul_done) begin
          if (last_q) begin
            mul_start = 1'b1;
            mul_x     = mul_prod ^ len_q;
            state_d   = S_FINAL;
          end else begin
            y_d     = mul_prod;
            state_d = S_WAIT_BLK;
          end
        end
      end
      S_FINAL: begin
        if (mul_done) begin
          otag_d  = mul_prod ^ j0_q;
          ok_d    = ((mul_prod ^ j0_q) == tag_q);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      j0_q    <= '0;
      len_q   <= '0;
      tag_q   <= '0;
      y_q     <= '0;
      otag_q  <= '0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      j0_q    <= j0_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
      y_q     <= y_d;
      otag_q  <= otag_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
    end
  end

endmodule
